// File: rtl/proc_pkg.sv
// Shared pipeline constants: memory-port arbiter state encodings and
// steering-mux select values.
package proc_pkg;

  localparam logic [1:0] ARB_IDLE   = 2'b00;
  localparam logic [1:0] ARB_BUSY_I = 2'b01;
  localparam logic [1:0] ARB_BUSY_D = 2'b10;

  localparam logic SEL_I = 1'b0;
  localparam logic SEL_D = 1'b1;

  function automatic logic arb_is_busy(input logic [1:0] state);
    return state != ARB_IDLE;
  endfunction

endpackage

// File: rtl/arb_pick.sv
// Winner selection for the shared memory port: data wins unless the fetch
// side has waited out the data streak limit.
module arb_pick (
  input  logic i_ireq,
  input  logic i_dreq,
  input  logic i_limit,
  output logic o_grant_i,
  output logic o_grant_d
);

  assign o_grant_d = i_dreq & ~(i_limit & i_ireq);
  assign o_grant_i = i_ireq & ~o_grant_d;

endmodule

// File: rtl/mem_port_arb.sv
// Fetch/data arbiter for the single memory port; drives the mux_2 select.
// Optional MACK watchdog enabled by defining MEM_ARB_TIMEOUT_EN.
module mem_port_arb
  import proc_pkg::*;
#(
  parameter int MAX_D_STREAK = 4,
  parameter int TIMEOUT      = 15
) (
  input  logic CLK,
  input  logic RST,
  input  logic IREQ,
  input  logic DREQ,
  input  logic MACK,
  output logic SEL,
  output logic MREQ,
  output logic IDONE,
  output logic DDONE,
  output logic ISTALL,
  output logic DSTALL,
  output logic ERR
);

  localparam int SW = (MAX_D_STREAK < 1) ? 1 : $clog2(MAX_D_STREAK + 1);
  localparam logic [SW-1:0] STREAK_MAX = SW'(MAX_D_STREAK);

  if (MAX_D_STREAK < 1 || TIMEOUT < 1) begin : g_param_check
    $error("mem_port_arb: MAX_D_STREAK and TIMEOUT must be at least 1");
  end

  logic [1:0]    r_state, w_state_next;
  logic          r_sel, w_sel_next;
  logic          r_mreq;
  logic [SW-1:0] r_streak, w_streak_next;
  logic          w_busy, w_arb_en, w_ireq_eff, w_dreq_eff, w_limit;
  logic          w_grant_i, w_grant_d, w_done_i, w_done_d, w_tmo_hit;

  // The requester being acknowledged this cycle is masked so it cannot win twice.
  assign w_busy     = arb_is_busy(r_state);
  assign w_arb_en   = ~w_busy | MACK;
  assign w_ireq_eff = IREQ & (r_state != ARB_BUSY_I);
  assign w_dreq_eff = DREQ & (r_state != ARB_BUSY_D);
  assign w_limit    = (r_streak == STREAK_MAX);

  arb_pick u_pick (
    .i_ireq    (w_ireq_eff),
    .i_dreq    (w_dreq_eff),
    .i_limit   (w_limit),
    .o_grant_i (w_grant_i),
    .o_grant_d (w_grant_d)
  );

  assign w_done_i = (r_state == ARB_BUSY_I) & MACK & ~RST;
  assign w_done_d = (r_state == ARB_BUSY_D) & MACK & ~RST;

`ifdef MEM_ARB_TIMEOUT_EN
  localparam int TW = ($clog2(TIMEOUT + 1) < 4) ? 4 : $clog2(TIMEOUT + 1);

  logic [TW-1:0] r_tmo;
  logic          r_err;

  assign w_tmo_hit = w_busy & ~MACK & (r_tmo == TW'(TIMEOUT - 1));

  always_ff @(posedge CLK) begin
    if (RST) begin
      r_tmo <= '0;
      r_err <= 1'b0;
    end else begin
      r_err <= w_tmo_hit;
      r_tmo <= (w_busy & ~MACK & ~w_tmo_hit) ? r_tmo + TW'(1) : '0;
    end
  end

  assign ERR = r_err;
`else
  assign w_tmo_hit = 1'b0;
  assign ERR       = 1'b0;
`endif

  always_comb begin
    w_state_next  = r_state;
    w_sel_next    = r_sel;
    w_streak_next = r_streak;
    if (w_arb_en) begin
      if (w_grant_d) begin
        w_state_next  = ARB_BUSY_D;
        w_sel_next    = SEL_D;
        w_streak_next = w_ireq_eff ? (w_limit ? r_streak : r_streak + SW'(1)) : '0;
      end else if (w_grant_i) begin
        w_state_next  = ARB_BUSY_I;
        w_sel_next    = SEL_I;
        w_streak_next = '0;
      end else begin
        w_state_next = ARB_IDLE;
      end
    end else if (w_tmo_hit) begin
      w_state_next = ARB_IDLE;
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      r_state  <= ARB_IDLE;
      r_sel    <= SEL_I;
      r_mreq   <= 1'b0;
      r_streak <= '0;
    end else begin
      r_state  <= w_state_next;
      r_sel    <= w_sel_next;
      r_mreq   <= arb_is_busy(w_state_next);
      r_streak <= w_streak_next;
    end
  end

  assign SEL    = r_sel;
  assign MREQ   = r_mreq;
  assign IDONE  = w_done_i;
  assign DDONE  = w_done_d;
  assign ISTALL = IREQ & ~w_done_i;
  assign DSTALL = DREQ & ~w_done_d;

endmodule

// File: tb/tb_mem_port_arb.sv
// Directed bench for mem_port_arb; observed vector per cycle is
// {SEL, MREQ, IDONE, DDONE, ISTALL, DSTALL, ERR}.
module tb_mem_port_arb;

  logic CLK = 1'b0;
  logic RST, IREQ, DREQ, MACK;
  logic SEL, MREQ, IDONE, DDONE, ISTALL, DSTALL, ERR;

  int n_checks = 0;
  int n_fail   = 0;

  mem_port_arb #(.MAX_D_STREAK(4), .TIMEOUT(15)) dut (
    .CLK    (CLK),
    .RST    (RST),
    .IREQ   (IREQ),
    .DREQ   (DREQ),
    .MACK   (MACK),
    .SEL    (SEL),
    .MREQ   (MREQ),
    .IDONE  (IDONE),
    .DDONE  (DDONE),
    .ISTALL (ISTALL),
    .DSTALL (DSTALL),
    .ERR    (ERR)
  );

  always #5 CLK = ~CLK;

  // Advance to just after the next rising edge; inputs are then set for that cycle.
  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic drive(input logic ireq, input logic dreq, input logic mack);
    IREQ = ireq;
    DREQ = dreq;
    MACK = mack;
    #1;
  endtask

  task automatic test_reset();
    logic [6:0] obs;
    RST = 1'b1;
    drive(1'b0, 1'b0, 1'b0);
    tick();
    tick();
    obs = {SEL, MREQ, IDONE, DDONE, ISTALL, DSTALL, ERR};
    n_checks++;
    if (obs !== 7'b0000000) begin
      n_fail++;
      $display("FAIL rst_hold obs=%b exp=%b", obs, 7'b0000000);
    end else $display("rst_hold obs=%b", obs);
    RST = 1'b0;
    tick();
    drive(1'b0, 1'b0, 1'b0);
    obs = {SEL, MREQ, IDONE, DDONE, ISTALL, DSTALL, ERR};
    n_checks++;
    if (obs !== 7'b0000000) begin
      n_fail++;
      $display("FAIL rst_release obs=%b exp=%b", obs, 7'b0000000);
    end else $display("rst_release obs=%b", obs);
  endtask

  task automatic test_lone_i();
    logic [6:0] exp_v [4];
    logic [2:0] stim  [4];
    logic [6:0] obs;
    exp_v = '{7'b0000100, 7'b0100100, 7'b0110000, 7'b0000000};
    stim  = '{3'b100, 3'b100, 3'b101, 3'b000};
    for (int c = 0; c < 4; c++) begin
      if (c != 0) tick();
      drive(stim[c][2], stim[c][1], stim[c][0]);
      obs = {SEL, MREQ, IDONE, DDONE, ISTALL, DSTALL, ERR};
      n_checks++;
      if (obs !== exp_v[c]) begin
        n_fail++;
        $display("FAIL lone_i_c%0d obs=%b exp=%b", c, obs, exp_v[c]);
      end else $display("lone_i_c%0d obs=%b", c, obs);
    end
  endtask

  task automatic test_back_to_back();
    logic [6:0] exp_v [4];
    logic [2:0] stim  [4];
    logic [6:0] obs;
    exp_v = '{7'b0000110, 7'b1101100, 7'b0110000, 7'b0000000};
    stim  = '{3'b111, 3'b111, 3'b101, 3'b000};
    for (int c = 0; c < 4; c++) begin
      tick();
      drive(stim[c][2], stim[c][1], stim[c][0]);
      obs = {SEL, MREQ, IDONE, DDONE, ISTALL, DSTALL, ERR};
      n_checks++;
      if (obs !== exp_v[c]) begin
        n_fail++;
        $display("FAIL b2b_c%0d obs=%b exp=%b", c, obs, exp_v[c]);
      end else $display("b2b_c%0d obs=%b", c, obs);
    end
  endtask

  // Fetch request re-presented at every arbitration while data keeps winning.
  task automatic test_streak();
    logic [6:0] obs;
    logic [6:0] exp_idle;
    logic [6:0] exp_v [3];
    logic [2:0] stim  [3];
    for (int k = 1; k <= 4; k++) begin
      tick();
      drive(1'b1, 1'b1, 1'b0);
      exp_idle = (k == 1) ? 7'b0000110 : 7'b1000110;
      obs = {SEL, MREQ, IDONE, DDONE, ISTALL, DSTALL, ERR};
      n_checks++;
      if (obs !== exp_idle) begin
        n_fail++;
        $display("FAIL streak_idle%0d obs=%b exp=%b", k, obs, exp_idle);
      end else $display("streak_idle%0d obs=%b", k, obs);
      tick();
      drive(1'b0, 1'b1, 1'b1);
      obs = {SEL, MREQ, IDONE, DDONE, ISTALL, DSTALL, ERR};
      n_checks++;
      if (obs !== 7'b1101000) begin
        n_fail++;
        $display("FAIL streak_dgrant%0d obs=%b exp=%b", k, obs, 7'b1101000);
      end else $display("streak_dgrant%0d obs=%b", k, obs);
    end
    tick();
    drive(1'b1, 1'b1, 1'b0);
    obs = {SEL, MREQ, IDONE, DDONE, ISTALL, DSTALL, ERR};
    n_checks++;
    if (obs !== 7'b1000110) begin
      n_fail++;
      $display("FAIL streak_idle5 obs=%b exp=%b", obs, 7'b1000110);
    end else $display("streak_idle5 obs=%b", obs);
    exp_v = '{7'b0110010, 7'b1101000, 7'b1000000};
    stim  = '{3'b111, 3'b011, 3'b000};
    for (int c = 0; c < 3; c++) begin
      tick();
      drive(stim[c][2], stim[c][1], stim[c][0]);
      obs = {SEL, MREQ, IDONE, DDONE, ISTALL, DSTALL, ERR};
      n_checks++;
      if (obs !== exp_v[c]) begin
        n_fail++;
        $display("FAIL streak_forced_c%0d obs=%b exp=%b", c, obs, exp_v[c]);
      end else $display("streak_forced_c%0d obs=%b", c, obs);
    end
  endtask

  task automatic test_reset_mid_busy();
    logic [6:0] exp_v [5];
    logic [3:0] stim  [5];
    logic [6:0] obs;
    exp_v = '{7'b1000010, 7'b1100010, 7'b1100010, 7'b0000000, 7'b0000000};
    stim  = '{4'b0010, 4'b0010, 4'b1011, 4'b0001, 4'b0000};
    for (int c = 0; c < 5; c++) begin
      tick();
      RST = stim[c][3];
      drive(stim[c][2], stim[c][1], stim[c][0]);
      obs = {SEL, MREQ, IDONE, DDONE, ISTALL, DSTALL, ERR};
      n_checks++;
      if (obs !== exp_v[c]) begin
        n_fail++;
        $display("FAIL rst_mid_c%0d obs=%b exp=%b", c, obs, exp_v[c]);
      end else $display("rst_mid_c%0d obs=%b", c, obs);
    end
    RST = 1'b0;
  endtask

  task automatic test_timeout();
    logic [6:0] obs;
    logic [6:0] exp_c;
    int n_busy;
`ifdef MEM_ARB_TIMEOUT_EN
    n_busy = 17;
`else
    n_busy = 20;
`endif
    tick();
    drive(1'b0, 1'b1, 1'b0);
    obs = {SEL, MREQ, IDONE, DDONE, ISTALL, DSTALL, ERR};
    n_checks++;
    if (obs !== 7'b0000010) begin
      n_fail++;
      $display("FAIL tmo_idle obs=%b exp=%b", obs, 7'b0000010);
    end else $display("tmo_idle obs=%b", obs);
    for (int c = 1; c <= n_busy; c++) begin
      tick();
      drive(1'b0, 1'b1, 1'b0);
      exp_c = 7'b1100010;
`ifdef MEM_ARB_TIMEOUT_EN
      if (c == 16) exp_c = 7'b1000011;
`endif
      obs = {SEL, MREQ, IDONE, DDONE, ISTALL, DSTALL, ERR};
      n_checks++;
      if (obs !== exp_c) begin
        n_fail++;
        $display("FAIL tmo_busy%0d obs=%b exp=%b", c, obs, exp_c);
      end else $display("tmo_busy%0d obs=%b", c, obs);
    end
    tick();
    drive(1'b0, 1'b1, 1'b1);
    obs = {SEL, MREQ, IDONE, DDONE, ISTALL, DSTALL, ERR};
    n_checks++;
    if (obs !== 7'b1101000) begin
      n_fail++;
      $display("FAIL tmo_ack obs=%b exp=%b", obs, 7'b1101000);
    end else $display("tmo_ack obs=%b", obs);
    tick();
    drive(1'b0, 1'b0, 1'b0);
    obs = {SEL, MREQ, IDONE, DDONE, ISTALL, DSTALL, ERR};
    n_checks++;
    if (obs !== 7'b1000000) begin
      n_fail++;
      $display("FAIL tmo_end obs=%b exp=%b", obs, 7'b1000000);
    end else $display("tmo_end obs=%b", obs);
  endtask

  initial begin
    RST  = 1'b1;
    IREQ = 1'b0;
    DREQ = 1'b0;
    MACK = 1'b0;
    test_reset();
    test_lone_i();
    test_back_to_back();
    test_streak();
    test_reset_mid_busy();
    test_timeout();
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
